// File: rtl/seq_int_div_if.sv
// Start/ready request and done/result bundle for the sequential divider.
interface seq_int_div_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_int_div.sv
// Restoring shift-subtract divider: one quotient bit per cycle on magnitudes,
// sign correction in a final FIX cycle; truncates toward zero.
module seq_int_div #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1
) (
  input logic         clk,
  input logic         rst_n,
  seq_int_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           count;
  logic [WIDTH:0]          rem;
  logic [WIDTH-1:0]        quo;
  logic [WIDTH-1:0]        mag_d;
  logic [WIDTH-1:0]        dividend_l;
  logic                    q_neg, r_neg, dz, ov;
  logic [WIDTH+1:0]        shifted;
  logic signed [WIDTH+1:0] trial;
  logic                    accept;
  logic [WIDTH-1:0]        quotient, remainder;
  logic                    div_by_zero, overflow;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (SIGNED && v[WIDTH-1]) return -v;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? -v : v;
  endfunction

  assign accept = (state == IDLE) && bus.start;

  // The partial remainder never exceeds the divisor magnitude, so the top bit
  // of shifted stays zero and the sign of trial is a clean borrow flag.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = $signed(shifted) - $signed({2'b00, mag_d});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = CALC;
      CALC: if (count == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              count <= '0;
    else if (accept)         count <= CW'(WIDTH);
    else if (state == CALC)  count <= count - CW'(1);
  end

  // Working datapath: loaded on acceptance, iterated in CALC
  always_ff @(posedge clk) begin
    if (accept) begin
      mag_d      <= magnitude(bus.divisor);
      quo        <= magnitude(bus.dividend);
      rem        <= '0;
      dividend_l <= bus.dividend;
      q_neg      <= SIGNED && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_neg      <= SIGNED && bus.dividend[WIDTH-1];
      dz         <= (bus.divisor == '0);
      ov         <= SIGNED && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                           && (bus.divisor == '1);
    end else if (state == CALC) begin
      rem <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
      quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
    end
  end

  // FIX: sign correction and status; overflow falls out of the magnitude path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (state == FIX) begin
      if (dz) begin
        quotient  <= '1;
        remainder <= dividend_l;
      end else begin
        quotient  <= apply_sign(quo, q_neg);
        remainder <= apply_sign(rem[WIDTH-1:0], r_neg);
      end
      div_by_zero <= dz;
      overflow    <= ov;
    end
  end

  assign bus.ready       = (state == IDLE);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;
  assign bus.overflow    = overflow;
endmodule

// File: tb/tb_seq_int_div.sv
// Directed bench for seq_int_div: signed/unsigned 8-bit units and a 16-bit unit.
module tb_seq_int_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_int_div_if #(.WIDTH(8))  s8 ();
  seq_int_div_if #(.WIDTH(8))  u8 ();
  seq_int_div_if #(.WIDTH(16)) s16 ();

  seq_int_div #(.WIDTH(8),  .SIGNED(1)) dut_s8  (.clk(clk), .rst_n(rst_n), .bus(s8));
  seq_int_div #(.WIDTH(8),  .SIGNED(0)) dut_u8  (.clk(clk), .rst_n(rst_n), .bus(u8));
  seq_int_div #(.WIDTH(16), .SIGNED(1)) dut_s16 (.clk(clk), .rst_n(rst_n), .bus(s16));

  typedef struct {
    int          u;
    logic [15:0] a, b, q, r;
    logic        dz, ov;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] got_q, got_r;
  logic        got_dz, got_ov;
  int          got_lat;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_in(input int u, input logic st, input logic [15:0] a, input logic [15:0] b);
    case (u)
      0: begin s8.start = st;  s8.dividend = a[7:0];  s8.divisor = b[7:0];  end
      1: begin u8.start = st;  u8.dividend = a[7:0];  u8.divisor = b[7:0];  end
      default: begin s16.start = st; s16.dividend = a; s16.divisor = b; end
    endcase
  endtask

  function automatic logic dn(input int u);
    case (u)
      0: return s8.done;
      1: return u8.done;
      default: return s16.done;
    endcase
  endfunction

  function automatic logic rdy(input int u);
    case (u)
      0: return s8.ready;
      1: return u8.ready;
      default: return s16.ready;
    endcase
  endfunction

  task automatic read_out(input int u);
    case (u)
      0: begin got_q = {8'h0, s8.quotient}; got_r = {8'h0, s8.remainder};
               got_dz = s8.div_by_zero; got_ov = s8.overflow; end
      1: begin got_q = {8'h0, u8.quotient}; got_r = {8'h0, u8.remainder};
               got_dz = u8.div_by_zero; got_ov = u8.overflow; end
      default: begin got_q = s16.quotient; got_r = s16.remainder;
               got_dz = s16.div_by_zero; got_ov = s16.overflow; end
    endcase
  endtask

  // Latency counts posedges from the accepting edge (1) to the edge after which done is seen.
  task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    for (int i = 0; i < 50 && !rdy(u); i++) @(negedge clk);
    set_in(u, 1'b1, a, b);
    got_lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) set_in(u, 1'b0, 16'hA5A5, 16'h5A5A);
      if (dn(u)) begin
        got_lat = n;
        read_out(u);
        break;
      end
    end
    if (got_lat == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int d0, d1;
    bit seen;

    set_in(0, 1'b0, 16'h0, 16'h0);
    set_in(1, 1'b0, 16'h0, 16'h0);
    set_in(2, 1'b0, 16'h0, 16'h0);

    vecs.push_back('{0, 16'd10,   16'd80,   16'd0,    16'd10,   1'b0, 1'b0});
    vecs.push_back('{0, 16'd120,  16'd34,   16'd3,    16'd18,   1'b0, 1'b0});
    vecs.push_back('{0, 16'd24,   16'd6,    16'd4,    16'd0,    1'b0, 1'b0});
    vecs.push_back('{0, 16'hF8,   16'h02,   16'hFC,   16'h00,   1'b0, 1'b0});
    vecs.push_back('{0, 16'h30,   16'hFC,   16'hF4,   16'h00,   1'b0, 1'b0});
    vecs.push_back('{0, 16'hD3,   16'hFB,   16'h09,   16'h00,   1'b0, 1'b0});
    vecs.push_back('{0, 16'hF9,   16'h02,   16'hFD,   16'hFF,   1'b0, 1'b0});
    vecs.push_back('{0, 16'h7F,   16'h01,   16'h7F,   16'h00,   1'b0, 1'b0});
    vecs.push_back('{0, 16'h80,   16'h01,   16'h80,   16'h00,   1'b0, 1'b0});
    vecs.push_back('{0, 16'h80,   16'h02,   16'hC0,   16'h00,   1'b0, 1'b0});
    vecs.push_back('{0, 16'h2A,   16'h00,   16'hFF,   16'h2A,   1'b1, 1'b0});
    vecs.push_back('{0, 16'h80,   16'hFF,   16'h80,   16'h00,   1'b0, 1'b1});
    vecs.push_back('{0, 16'd24,   16'd6,    16'd4,    16'd0,    1'b0, 1'b0});
    vecs.push_back('{0, 16'h85,   16'h00,   16'hFF,   16'h85,   1'b1, 1'b0});
    vecs.push_back('{1, 16'hF8,   16'h02,   16'h7C,   16'h00,   1'b0, 1'b0});
    vecs.push_back('{1, 16'hFF,   16'h10,   16'h0F,   16'h0F,   1'b0, 1'b0});
    vecs.push_back('{1, 16'h80,   16'hFF,   16'h00,   16'h80,   1'b0, 1'b0});
    vecs.push_back('{2, 16'h8AD0, 16'h0007, 16'hEF43, 16'hFFFB, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(s8.ready), 32'd1);
    check("rst_done", 32'(s8.done), 32'd0);
    check("rst_q", 32'(s8.quotient), 32'd0);
    check("rst_r", 32'(s8.remainder), 32'd0);
    check("rst_flags", {30'd0, s8.div_by_zero, s8.overflow}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].u, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_lat", i), 32'(got_lat), (vecs[i].u == 2) ? 32'd18 : 32'd10);
      check($sformatf("v%0d_q", i), 32'(got_q), 32'(vecs[i].q));
      check($sformatf("v%0d_r", i), 32'(got_r), 32'(vecs[i].r));
      check($sformatf("v%0d_dz", i), 32'(got_dz), 32'(vecs[i].dz));
      check($sformatf("v%0d_ov", i), 32'(got_ov), 32'(vecs[i].ov));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(dn(vecs[i].u)), 32'd0);
      check($sformatf("v%0d_ready_back", i), 32'(rdy(vecs[i].u)), 32'd1);
    end

    // start pulsed mid-CALC with other operands must be ignored
    @(negedge clk);
    set_in(0, 1'b1, 16'd120, 16'd34);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) set_in(0, 1'b0, 16'd0, 16'd0);
      if (n == 4) begin
        set_in(0, 1'b1, 16'd10, 16'd80);
        check("busy_ready", 32'(s8.ready), 32'd0);
      end
      if (n == 5) set_in(0, 1'b0, 16'd0, 16'd0);
      if (s8.done) begin lat = n; read_out(0); break; end
    end
    check("ign_lat", 32'(lat), 32'd10);
    check("ign_q", 32'(got_q), 32'd3);
    check("ign_r", 32'(got_r), 32'd18);
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (s8.done) seen = 1'b1;
    end
    check("ign_no_extra_done", 32'(seen), 32'd0);

    // start held high: accepted every WIDTH+3 cycles
    @(negedge clk);
    set_in(0, 1'b1, 16'd24, 16'd6);
    d0 = -1; d1 = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (s8.done) begin
        if (d0 < 0) d0 = n;
        else begin d1 = n; break; end
      end
    end
    set_in(0, 1'b0, 16'd0, 16'd0);
    check("cont_first", 32'(d0), 32'd10);
    check("cont_spacing", 32'(d1 - d0), 32'd11);
    check("cont_q", 32'(s8.quotient), 32'd4);

    // reset mid-CALC, after an op that leaves nonzero outputs and a flag
    run_op(0, 16'h2A, 16'h00);
    check("pre_rst_dz", 32'(got_dz), 32'd1);
    @(negedge clk);
    set_in(0, 1'b1, 16'd120, 16'd34);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    set_in(0, 1'b1, 16'd10, 16'd80);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 1'b0, 16'd0, 16'd0);
    check("mid_rst_ready", 32'(s8.ready), 32'd1);
    check("mid_rst_done", 32'(s8.done), 32'd0);
    check("mid_rst_q", 32'(s8.quotient), 32'd0);
    check("mid_rst_r", 32'(s8.remainder), 32'd0);
    check("mid_rst_flags", {30'd0, s8.div_by_zero, s8.overflow}, 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (s8.done) seen = 1'b1;
    end
    check("mid_rst_no_done", 32'(seen), 32'd0);
    run_op(0, 16'd120, 16'd34);
    check("post_rst_lat", 32'(got_lat), 32'd10);
    check("post_rst_q", 32'(got_q), 32'd3);
    check("post_rst_r", 32'(got_r), 32'd18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
